// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int OVERSAMPLE    = 16;
  localparam int MID_SAMPLE    = 8;
  localparam int TIMEOUT_BITS  = 32;
  localparam int TIMEOUT_TICKS = TIMEOUT_BITS * OVERSAMPLE;

endpackage

// File: rtl/uart_rx_core.sv
// Receive front end: synchroniser, 3-sample majority, 16x prescaler and frame FSM.
// Emits a one-cycle frame_valid on the edge where the stop bit is sampled.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_divider,
  input  logic                 parity_en,
  input  logic                 parity_type_odd,
  output logic                 tick,
  output logic                 rx_idle,
  output logic                 frame_valid,
  output logic [DATA_BITS-1:0] frame_data,
  output logic                 frame_parity_err,
  output logic                 frame_frame_err
);

  logic                 sync1, sync2;
  logic [2:0]           samples;
  logic                 line;
  logic [DIV_W-1:0]     presc_cnt;
  uart_rx_state_t       state, state_next;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_en_q, par_odd_q, perr_q;
  logic                 sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      samples <= 3'b111;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      samples <= {samples[1:0], sync2};
    end
  end

  assign line = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);

  // Free-running prescaler; >= keeps it sane if the divider shrinks mid-count.
  assign tick = (presc_cnt >= baud_divider);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_cnt <= '0;
    else        presc_cnt <= tick ? '0 : presc_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    sample      = 1'b0;
    state_next  = state;
    frame_valid = 1'b0;
    if (tick) begin
      if (state == START) sample = (tick_cnt == 4'(MID_SAMPLE));
      else                sample = (tick_cnt == 4'(OVERSAMPLE - 1));
    end
    case (state)
      IDLE:      if (!line) state_next = START;
      START:     if (sample) state_next = line ? IDLE : DATA;
      DATA:      if (sample && bit_cnt == 4'(DATA_BITS - 1)) state_next = par_en_q ? PARITY : STOP;
      PARITY:    if (sample) state_next = STOP;
      STOP: begin
        if (sample) begin
          frame_valid = 1'b1;
          state_next  = line ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (line) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Bit timing restarts at the start-bit midpoint so every later bit lands mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      data_sr   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (tick) tick_cnt <= tick_cnt + 4'd1;
      case (state)
        IDLE: begin
          if (!line) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            perr_q    <= 1'b0;
            par_en_q  <= parity_en;
            par_odd_q <= parity_type_odd;
          end
        end
        START:  if (sample) tick_cnt <= '0;
        DATA: begin
          if (sample) begin
            data_sr <= {line, data_sr[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        PARITY: if (sample) perr_q <= ((^data_sr) ^ line) != par_odd_q;
        default: ;
      endcase
    end
  end

  assign rx_idle          = (state == IDLE);
  assign frame_data       = data_sr;
  assign frame_parity_err = perr_q;
  assign frame_frame_err  = ~line;

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered UART receiver: rx core feeding a first-word-fall-through FIFO with sticky overrun.
// Optional idle timeout flag is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_BITS-1:0]            m_data,
  output logic                            m_parity_err,
  output logic                            m_frame_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            buffer_empty,
  output logic                            buffer_full,
  output logic                            overrun,
  input  logic                            clear_errors,
  input  logic [DIV_W-1:0]                baud_divider,
  input  logic                            parity_en,
  input  logic                            parity_type_odd
`ifdef UART_RX_FIFO_TIMEOUT_EN
  ,
  output logic                            rx_timeout
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  logic                 tick, rx_idle, frame_valid, frame_parity_err, frame_frame_err;
  logic [DATA_BITS-1:0] frame_data;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr, rd_ptr_next;
  logic [LW-1:0]        level_next;
  logic [EW-1:0]        push_word, head_next;
  logic                 do_push, do_pop;

  uart_rx_core #(
    .DATA_BITS (DATA_BITS),
    .DIV_W     (DIV_W)
  ) u_core (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx               (rx),
    .baud_divider     (baud_divider),
    .parity_en        (parity_en),
    .parity_type_odd  (parity_type_odd),
    .tick             (tick),
    .rx_idle          (rx_idle),
    .frame_valid      (frame_valid),
    .frame_data       (frame_data),
    .frame_parity_err (frame_parity_err),
    .frame_frame_err  (frame_frame_err)
  );

  assign buffer_empty = (level == '0);
  assign buffer_full  = (level == LW'(FIFO_DEPTH));
  assign do_pop       = m_valid && m_ready;
  assign do_push      = frame_valid && (!buffer_full || do_pop);
  assign push_word    = {frame_parity_err, frame_frame_err, frame_data};

  // Head register is preloaded with whatever will sit at the read pointer after this edge.
  always_comb begin
    rd_ptr_next = do_pop ? rd_ptr + PW'(1) : rd_ptr;
    level_next  = level;
    if (do_push && !do_pop)      level_next = level + LW'(1);
    else if (!do_push && do_pop) level_next = level - LW'(1);
    head_next = (do_push && rd_ptr_next == wr_ptr) ? push_word : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr  <= rd_ptr_next;
      level   <= level_next;
      m_valid <= (level_next != '0);
      if (level_next != '0) {m_parity_err, m_frame_err, m_data} <= head_next;
      if (frame_valid && !do_push) overrun <= 1'b1;
      else if (clear_errors)       overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts idle ticks only while data is waiting; a start bit or an empty FIFO restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt     <= '0;
      rx_timeout <= 1'b0;
    end else if (clear_errors || !rx_idle || level == '0) begin
      to_cnt     <= '0;
      rx_timeout <= 1'b0;
    end else if (tick && !rx_timeout) begin
      if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) rx_timeout <= 1'b1;
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout_inputs;
  assign unused_timeout_inputs = ^{tick, rx_idle};
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with an expected-frame scoreboard (8 data bits, depth 16, divider 0).
module tb_uart_rx_fifo;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV_W      = 12;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 rx;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_parity_err;
  logic                 m_frame_err;
  logic [LW-1:0]        level;
  logic                 buffer_empty;
  logic                 buffer_full;
  logic                 overrun;
  logic                 clear_errors;
  logic [DIV_W-1:0]     baud_divider;
  logic                 parity_en;
  logic                 parity_type_odd;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic                 rx_timeout;
`endif

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  uart_rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx              (rx),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_parity_err    (m_parity_err),
    .m_frame_err     (m_frame_err),
    .level           (level),
    .buffer_empty    (buffer_empty),
    .buffer_full     (buffer_full),
    .overrun         (overrun),
    .clear_errors    (clear_errors),
    .baud_divider    (baud_divider),
    .parity_en       (parity_en),
    .parity_type_odd (parity_type_odd)
`ifdef UART_RX_FIFO_TIMEOUT_EN
    ,
    .rx_timeout      (rx_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // With divider 0 one bit period is 16 clocks.
  task automatic driveBit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                               input bit expect_entry);
    exp_t e;
    e.data = d;
    e.perr = parity_en && (((^d) ^ par_bit) != parity_type_odd);
    e.ferr = !stop_bit;
    if (expect_entry) sb.push_back(e);
    @(negedge clk);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    if (parity_en) driveBit(par_bit);
    driveBit(stop_bit);
  endtask

  task automatic drainOne(input string tag);
    exp_t e;
    int   waited;
    e = sb.pop_front();
    waited = 0;
    while (!m_valid && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_valid"}, 32'(m_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(m_data), 32'(e.data));
    checkOutput({tag, "_perr"}, 32'(m_parity_err), 32'(e.perr));
    checkOutput({tag, "_ferr"}, 32'(m_frame_err), 32'(e.ferr));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic drainAll(input string tag);
    while (sb.size() > 0) drainOne(tag);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "_level"}, 32'(level), 32'd0);
    checkOutput({tag, "_empty"}, 32'(buffer_empty), 32'd1);
    checkOutput({tag, "_full"}, 32'(buffer_full), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
    checkOutput({tag, "_m_data"}, 32'(m_data), 32'd0);
    checkOutput({tag, "_m_perr"}, 32'(m_parity_err), 32'd0);
    checkOutput({tag, "_m_ferr"}, 32'(m_frame_err), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rx              = 1'b1;
    rst_n           = 1'b0;
    m_ready         = 1'b0;
    clear_errors    = 1'b0;
    baud_divider    = '0;
    parity_en       = 1'b0;
    parity_type_odd = 1'b0;
    waitClocks(3);
    checkResetState("reset");
    rst_n = 1'b1;
    waitClocks(5);

    $display("[TB] 8N1 frame 0xA5");
    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1);
    checkOutput("a5_level", 32'(level), 32'd1);
    drainAll("a5");
    checkOutput("a5_empty_after", 32'(buffer_empty), 32'd1);

    $display("[TB] odd parity, bad then good");
    parity_en       = 1'b1;
    parity_type_odd = 1'b1;
    applyStimulus(8'h03, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b1);
    drainAll("par");
    parity_en       = 1'b0;
    parity_type_odd = 1'b0;

    $display("[TB] framing error with held break");
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    rx = 1'b0;
    waitClocks(40 * 16);
    rx = 1'b1;
    waitClocks(64);
    checkOutput("brk_level", 32'(level), 32'd1);
    drainAll("brk");
    checkOutput("brk_empty_after", 32'(buffer_empty), 32'd1);

    $display("[TB] overrun with 17 frames");
    for (int i = 0; i < 17; i++) applyStimulus(8'(i * 13 + 1), 1'b0, 1'b1, i < 16);
    waitClocks(4);
    checkOutput("ovr_level", 32'(level), 32'(FIFO_DEPTH));
    checkOutput("ovr_full", 32'(buffer_full), 32'd1);
    checkOutput("ovr_overrun", 32'(overrun), 32'd1);
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    checkOutput("ovr_cleared", 32'(overrun), 32'd0);
    drainAll("ovr");
    waitClocks(2);
    checkOutput("ovr_level_after", 32'(level), 32'd0);
    checkOutput("ovr_valid_after", 32'(m_valid), 32'd0);

    $display("[TB] glitch rejection");
    @(negedge clk);
    rx = 1'b0;
    waitClocks(3);
    rx = 1'b1;
    waitClocks(80);
    checkOutput("glitch_level", 32'(level), 32'd0);
    checkOutput("glitch_valid", 32'(m_valid), 32'd0);
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1);
    waitClocks(4);
    checkOutput("post_glitch_level", 32'(level), 32'd1);
    checkOutput("post_glitch_data", 32'(m_data), 32'h3C);

    $display("[TB] reset mid-frame");
    @(negedge clk);
    rx = 1'b0;
    waitClocks(60);
    rst_n = 1'b0;
    sb.delete();
    waitClocks(2);
    checkResetState("midrst");
    rx = 1'b1;
    waitClocks(2);
    rst_n = 1'b1;
    waitClocks(200);
    checkOutput("midrst_level_after", 32'(level), 32'd0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    $display("[TB] idle timeout");
    begin
      int waited;
      applyStimulus(8'h77, 1'b0, 1'b1, 1'b1);
      waitClocks(440);
      checkOutput("to_early", 32'(rx_timeout), 32'd0);
      waited = 0;
      while (!rx_timeout && waited < 150) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("to_rise", 32'(rx_timeout), 32'd1);
      drainAll("to");
      waitClocks(2);
      checkOutput("to_clear_on_pop", 32'(rx_timeout), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
